// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, 2-entry in-order fetch queue and IF/ID register.
// Responses are matched to requests purely by order; drop_cnt swallows the
// responses still in flight when a redirect discards their queue entries.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr_data,
  output logic [31:0] if_id_pc
);

  logic [31:0]      pc;
  logic [1:0]       q_vld, q_done;       // slot 0 is always the head
  logic [1:0][31:0] q_pc, q_instr;
  logic [1:0]       drop_cnt;

  logic [1:0]       occ, nd_cnt;
  logic             pop, accept, fill, fill_idx, tail;
  logic [1:0]       n_vld, n_done;
  logic [1:0][31:0] n_pc, n_instr;
  logic [2:0]       drop_sum;
  logic [1:0]       n_drop;
  logic [31:0]      redirect_aligned;

  assign imem_addr        = pc;
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  // Handshake decode: pop frees its slot in the same cycle, so a full queue
  // whose head leaves can still issue a request.
  always_comb begin
    occ      = {1'b0, q_vld[0]} + {1'b0, q_vld[1]};
    nd_cnt   = {1'b0, q_vld[0] & ~q_done[0]} + {1'b0, q_vld[1] & ~q_done[1]};
    pop      = ~rst & ~redirect_en & ~stall & q_vld[0] & q_done[0];
    imem_req = ~rst & ~redirect_en & ((occ - {1'b0, pop}) < 2'd2);
    accept   = imem_req & imem_ready;
    fill     = ~rst & ~redirect_en & imem_rvalid & (drop_cnt == 2'd0);
    // entries complete in order, so the oldest not-done one is the head
    // unless the head is already done
    fill_idx = ~(q_vld[0] & ~q_done[0]);
  end

  // Queue next state: fill in place, then shift on pop, then allocate at tail.
  always_comb begin
    n_vld   = q_vld;
    n_done  = q_done;
    n_pc    = q_pc;
    n_instr = q_instr;
    if (fill) begin
      n_done[fill_idx]  = 1'b1;
      n_instr[fill_idx] = imem_rdata;
    end
    if (pop) begin
      n_vld      = {1'b0, n_vld[1]};
      n_done     = {1'b0, n_done[1]};
      n_pc[0]    = n_pc[1];
      n_instr[0] = n_instr[1];
    end
    tail = n_vld[0];
    if (accept) begin
      n_vld[tail]  = 1'b1;
      n_done[tail] = 1'b0;
      n_pc[tail]   = pc;
    end
  end

  // Drop counter: a redirect turns every outstanding request into a drop,
  // less the response consumed in the redirect cycle itself.
  always_comb begin
    drop_sum = {1'b0, nd_cnt} + {1'b0, drop_cnt} - {2'b00, imem_rvalid};
    n_drop   = drop_cnt;
    if (redirect_en)
      n_drop = drop_sum[1:0];
    else if (imem_rvalid && drop_cnt != 2'd0)
      n_drop = drop_cnt - 2'd1;
  end

  // PC, queue and drop counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      q_vld    <= '0;
      q_done   <= '0;
      drop_cnt <= '0;
    end else if (redirect_en) begin
      pc       <= redirect_aligned;
      q_vld    <= '0;
      q_done   <= '0;
      drop_cnt <= n_drop;
    end else begin
      if (accept) pc <= pc + 32'd4;
      q_vld    <= n_vld;
      q_done   <= n_done;
      drop_cnt <= n_drop;
    end
  end

  // Queue payload needs no reset; validity is tracked by q_vld.
  always_ff @(posedge clk) begin
    q_pc    <= n_pc;
    q_instr <= n_instr;
  end

  // IF/ID register: bubble when the head is not ready, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_instr_data <= NOP_INSTR;
      if_id_pc         <= '0;
    end else if (redirect_en) begin
      if_id_instr_data <= NOP_INSTR;
      if_id_pc         <= redirect_aligned;
    end else if (!stall) begin
      if (pop) begin
        if_id_instr_data <= q_instr[0];
        if_id_pc         <= q_pc[0];
      end else begin
        if_id_instr_data <= NOP_INSTR;
      end
    end
  end

  // A response must always have a not-done entry or a pending drop to go to.
  a_rsp_owner: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (drop_cnt != 2'd0 || nd_cnt != 2'd0));
  a_drop_max: assert property (@(posedge clk) disable iff (rst)
    redirect_en |-> (drop_sum <= 3'd2));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized traffic against a
// queue-based transaction model of the fetch stage and an in-order memory.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_instr_data, if_id_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_instr_data(if_id_instr_data), .if_id_pc(if_id_pc)
  );

  int tests = 0, fails = 0;

  // model: fetched-but-undelivered instructions, pending drops, PCs
  typedef struct { logic [31:0] pc; logic [31:0] instr; bit done; } ent_t;
  ent_t        q[$];
  int          drop;
  logic [31:0] m_pc, m_instr, m_ifpc;
  logic [31:0] mem_q[$];   // accepted addresses awaiting a response

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++; fails++;
    $display("FAIL %s: event not seen within bound", name);
  endtask

  task automatic model_reset();
    q.delete(); mem_q.delete(); drop = 0;
    m_pc = RESET_PC; m_instr = NOP; m_ifpc = '0;
  endtask

  // one clock cycle of stimulus, compare, and model advance
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                      input bit rdy, input bit rv);
    bit fire, pop, exp_req, acc;
    int nd, idx;
    fire = rv && (mem_q.size() > 0);
    rst = 1'b0; stall = st; redirect_en = rd; redirect_pc = rpc; imem_ready = rdy;
    imem_rvalid = fire;
    imem_rdata  = fire ? mem_word(mem_q[0]) : $urandom;
    pop     = !st && !rd && q.size() > 0 && q[0].done;
    exp_req = !rd && (q.size() - (pop ? 1 : 0)) < 2;
    @(negedge clk);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_instr", if_id_instr_data, m_instr);
    chk("if_id_pc", if_id_pc, m_ifpc);
    acc = exp_req && rdy;
    if (rd) begin
      nd = 0;
      foreach (q[i]) if (!q[i].done) nd++;
      drop = nd + drop - (fire ? 1 : 0);
      q.delete();
      m_pc = {rpc[31:2], 2'b00}; m_instr = NOP; m_ifpc = m_pc;
    end else begin
      if (fire) begin
        if (drop > 0) drop--;
        else begin
          idx = -1;
          foreach (q[i]) if (idx < 0 && !q[i].done) idx = i;
          if (idx >= 0) begin q[idx].instr = mem_word(mem_q[0]); q[idx].done = 1'b1; end
        end
      end
      if (pop) begin m_instr = q[0].instr; m_ifpc = q[0].pc; q.delete(0); end
      else if (!st) m_instr = NOP;
      if (acc) begin
        q.push_back('{pc: m_pc, instr: 32'h0, done: 1'b0});
        mem_q.push_back(m_pc);
        m_pc += 32'd4;
      end
    end
    if (fire) mem_q.delete(0);
    @(posedge clk); #1;
  endtask

  // one reset cycle with random (overridden) control inputs
  task automatic rst_step();
    rst = 1'b1; stall = 1'($urandom); redirect_en = 1'($urandom);
    redirect_pc = $urandom; imem_ready = 1'($urandom); imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    @(negedge clk);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, m_pc);
    chk("rst_if_id_instr", if_id_instr_data, m_instr);
    chk("rst_if_id_pc", if_id_pc, m_ifpc);
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) rst_step();
    rst = 1'b0; redirect_en = 1'b0; imem_rvalid = 1'b0;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
  endtask

  // scan for the first real instruction reaching decode
  task automatic expect_first(input string name, input logic [31:0] pc_exp);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (if_id_instr_data !== NOP) seen = 1'b1;
    end
    if (!seen) timeout(name);
    else begin
      chk({name, "_pc"}, if_id_pc, pc_exp);
      chk({name, "_instr"}, if_id_instr_data, mem_word(pc_exp));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0, p0;
    bit rv, rd, fire;
    int quiet;
    model_reset();
    @(posedge clk); #1;
    do_reset(3);

    // zero-wait streaming: decode sees 0,4,8,... from the third edge on
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (i >= 2) begin
        chk("stream_pc", if_id_pc, 32'(4 * (i - 2)));
        chk("stream_instr", if_id_instr_data, mem_word(32'(4 * (i - 2))));
      end
    end

    // stall 3 cycles with the queue full
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_pc", if_id_pc, 32'd20);
      chk("stall_instr", if_id_instr_data, mem_word(32'd20));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk("release_pc", if_id_pc, 32'(24 + 4 * i));
    end

    // redirect with two outstanding requests
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    chk("redir_instr", if_id_instr_data, NOP);
    chk("redir_pc", if_id_pc, 32'h100);
    chk("redir_addr", imem_addr, 32'h100);
    expect_first("redir_first", 32'h100);

    // redirect under stall with a response in the same cycle (unaligned target)
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0203, 1'b1, 1'b1);
    chk("redir_stall_instr", if_id_instr_data, NOP);
    chk("redir_stall_pc", if_id_pc, 32'h200);
    chk("redir_stall_addr", imem_addr, 32'h200);
    expect_first("redir_stall_first", 32'h200);

    // memory not ready: drain, then 4 cycles of bubbles with a stable address
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    a0 = m_pc; p0 = m_ifpc;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("nready_addr", imem_addr, a0);
      chk("nready_instr", if_id_instr_data, NOP);
      chk("nready_pc", if_id_pc, p0);
    end

    // wrap-around of the fetch PC
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    expect_first("wrap_first", 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_next_pc", if_id_pc, 32'h0000_0000);

    // randomized traffic with occasional resets
    quiet = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(499) == 0) begin do_reset(2); quiet = 2; end
      rv = (quiet == 0) && ($urandom_range(99) < 70);
      if (quiet > 0) quiet--;
      fire = rv && (mem_q.size() > 0);
      // keep the number of responses owed to discarded requests within 2
      rd = ($urandom_range(99) < 8) && ((mem_q.size() - (fire ? 1 : 0)) <= 2);
      step(($urandom_range(99) < 20), rd,
           ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom,
           ($urandom_range(99) < 75), rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
